// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic PE array: buffers an N x N operand matrix and streams it with lane i delayed i cycles.
// Optional macro SKEW_FEEDER_REPEAT_EN keeps the matrix after a stream so a later start replays it.
module systolic_skew_feeder #(
   parameter int N  = 4,
   parameter int DW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [N*DW-1:0] load_row,
   input  logic            start,
   input  logic            clear,
   output logic            busy,
   output logic            done,
   output logic [N*DW-1:0] edge_data,
   output logic [N-1:0]    edge_valid
);

   localparam int TW = (N > 1) ? $clog2(2*N-1) : 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam logic [TW-1:0] T_LAST   = TW'(2*N-2);
   localparam logic [RW-1:0] ROW_LAST = RW'(N-1);

   typedef enum logic [1:0] {EMPTY, READY, STREAM} state_t;

   state_t          state, state_nxt;
   logic [RW-1:0]   row_cnt;
   logic [TW-1:0]   t;
   logic [TW-1:0]   beat;
   logic            row_take, stream_go, stream_end;
   logic [DW-1:0]   buffer [N][N];
   logic [N*DW-1:0] beat_data;
   logic [N-1:0]    beat_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      row_take   = 1'b0;
      stream_go  = 1'b0;
      stream_end = 1'b0;
      case (state)
         EMPTY: begin
            if (load_valid) begin
               row_take = 1'b1;
               if (row_cnt == ROW_LAST) state_nxt = READY;
            end
         end
         READY: begin
            if (clear) begin
               state_nxt = EMPTY;
            end else if (start) begin
               stream_go = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (t == T_LAST) begin
               stream_end = 1'b1;
`ifdef SKEW_FEEDER_REPEAT_EN
               state_nxt  = READY;
`else
               state_nxt  = EMPTY;
`endif
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Gated by rst so every output reads 0 while reset is held.
   assign load_ready = (state == EMPTY) && !rst;
   assign busy       = (state == STREAM);

   // Beat to be registered on this edge: 0 when a stream launches, else the next one.
   assign beat = stream_go ? '0 : t + 1'b1;

   always_comb begin
      beat_data  = '0;
      beat_valid = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (beat == TW'(i + j)) begin
               beat_valid[i]        = 1'b1;
               beat_data[DW*i +: DW] = buffer[i][j];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt    <= '0;
         t          <= '0;
         edge_data  <= '0;
         edge_valid <= '0;
         done       <= 1'b0;
      end else begin
         done <= stream_end;
         if (row_take) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
         if (stream_end) begin
            t          <= '0;
            edge_data  <= '0;
            edge_valid <= '0;
         end else if (stream_go || state == STREAM) begin
            t          <= beat;
            edge_data  <= beat_data;
            edge_valid <= beat_valid;
         end
      end
   end

   // Buffer has no reset; its contents only matter once a full matrix is loaded.
   always_ff @(posedge clk) begin
      if (row_take) begin
         for (int j = 0; j < N; j++) buffer[row_cnt][j] <= load_row[DW*j +: DW];
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder (N=4, DW=4); covers SKEW_FEEDER_REPEAT_EN when defined.
module tb_systolic_skew_feeder;

   localparam int N  = 4;
   localparam int DW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            load_valid;
   logic            load_ready;
   logic [N*DW-1:0] load_row;
   logic            start;
   logic            clear;
   logic            busy;
   logic            done;
   logic [N*DW-1:0] edge_data;
   logic [N-1:0]    edge_valid;

   int checks   = 0;
   int failures = 0;

   systolic_skew_feeder #(.N(N), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_row   (load_row),
      .start      (start),
      .clear      (clear),
      .busy       (busy),
      .done       (done),
      .edge_data  (edge_data),
      .edge_valid (edge_valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Matrix 0 is A[i][j]=4i+j; matrix 1 is its reverse 15-(4i+j).
   function automatic logic [DW-1:0] elem(input int sel, input int i, input int j);
      int v;
      v = 4*i + j;
      if (sel != 0) v = 15 - v;
      return DW'(v);
   endfunction

   function automatic logic [N*DW-1:0] row_of(input int sel, input int r);
      logic [N*DW-1:0] row;
      row = '0;
      for (int j = 0; j < N; j++) row[DW*j +: DW] = elem(sel, r, j);
      return row;
   endfunction

   function automatic logic [N-1:0] exp_valid(input int t);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) if (t - i >= 0 && t - i < N) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [N*DW-1:0] exp_data(input int sel, input int t);
      logic [N*DW-1:0] d;
      d = '0;
      for (int i = 0; i < N; i++) if (t - i >= 0 && t - i < N) d[DW*i +: DW] = elem(sel, i, t - i);
      return d;
   endfunction

   task automatic load_rows(input int sel, input int first, input int last);
      for (int r = first; r <= last; r++) begin
         load_row   = row_of(sel, r);
         load_valid = 1'b1;
         check_eq("load_ready_accept", 32'(load_ready), 32'd1);
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic run_stream(input int sel, input bit hold_lv);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t <= 2*N-2; t++) begin
         check_eq("busy", 32'(busy), 32'd1);
         check_eq("done_early", 32'(done), 32'd0);
         check_eq("load_ready_stream", 32'(load_ready), 32'd0);
         check_eq("edge_valid", 32'(edge_valid), 32'(exp_valid(t)));
         check_eq("edge_data", 32'(edge_data), 32'(exp_data(sel, t)));
         if (sel == 0 && t <= 3) check_eq("lane0_A", 32'(edge_data[3:0]), 32'(t));
         if (sel == 0 && t >= 2 && t <= 5) check_eq("lane2_A", 32'(edge_data[11:8]), 32'(8 + t - 2));
         if (sel == 0 && t >= 3) check_eq("lane3_A", 32'(edge_data[15:12]), 32'(12 + t - 3));
         if (t == 0) check_eq("valid_t0", 32'(edge_valid), 32'h1);
         if (t == 3) check_eq("valid_t3", 32'(edge_valid), 32'hF);
         if (t == 6) check_eq("valid_t6", 32'(edge_valid), 32'h8);
         load_row   = 16'hA5A5;
         load_valid = hold_lv && (t < 2*N-2);
         tick();
      end
      load_valid = 1'b0;
      check_eq("done_pulse", 32'(done), 32'd1);
      check_eq("busy_end", 32'(busy), 32'd0);
      check_eq("edge_valid_end", 32'(edge_valid), 32'd0);
      check_eq("edge_data_end", 32'(edge_data), 32'd0);
      tick();
      check_eq("done_single", 32'(done), 32'd0);
   endtask

   task automatic to_empty();
`ifdef SKEW_FEEDER_REPEAT_EN
      check_eq("load_ready_repeat_ready", 32'(load_ready), 32'd0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
`endif
      check_eq("load_ready_empty", 32'(load_ready), 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_row   = '0;
      start      = 1'b0;
      clear      = 1'b0;
      #3;
      check_eq("rst_edge_valid", 32'(edge_valid), 32'd0);
      check_eq("rst_edge_data", 32'(edge_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      #9 rst = 1'b0;
      #1;
      check_eq("load_ready_after_rst", 32'(load_ready), 32'd1);

      // Full load, then a row offered in READY must be ignored.
      load_rows(0, 0, N-1);
      check_eq("load_ready_full", 32'(load_ready), 32'd0);
      load_row   = 16'hFFFF;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      check_eq("load_ready_ready", 32'(load_ready), 32'd0);
      run_stream(0, 1'b1);

`ifdef SKEW_FEEDER_REPEAT_EN
      check_eq("repeat_ready", 32'(load_ready), 32'd0);
      run_stream(0, 1'b0);
`endif
      to_empty();

      // start with only two rows loaded is ignored; loading then resumes at row 2.
      load_rows(1, 0, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("partial_start_busy", 32'(busy), 32'd0);
      check_eq("partial_start_valid", 32'(edge_valid), 32'd0);
      tick();
      check_eq("partial_start_busy2", 32'(busy), 32'd0);
      load_rows(1, 2, N-1);
      check_eq("load_ready_full_b", 32'(load_ready), 32'd0);
      run_stream(1, 1'b0);
      to_empty();

      // Reset during beat 3 aborts at once with no done pulse.
      load_rows(0, 0, N-1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check_eq("pre_rst_valid_t3", 32'(edge_valid), 32'hF);
      rst = 1'b1;
      #1;
      check_eq("midrst_edge_valid", 32'(edge_valid), 32'd0);
      check_eq("midrst_edge_data", 32'(edge_data), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      #2 rst = 1'b0;
      #1;
      check_eq("midrst_load_ready", 32'(load_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("midrst_no_done", 32'(done), 32'd0);
         check_eq("midrst_no_busy", 32'(busy), 32'd0);
      end

      // clear beats start when both are asserted in READY.
      load_rows(1, 0, N-1);
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      check_eq("clear_wins_busy", 32'(busy), 32'd0);
      check_eq("clear_wins_valid", 32'(edge_valid), 32'd0);
      check_eq("clear_wins_load_ready", 32'(load_ready), 32'd1);
      tick();
      check_eq("clear_wins_busy2", 32'(busy), 32'd0);
      load_rows(0, 0, N-1);
      run_stream(0, 1'b0);
      to_empty();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream edge feeder for the systolic processing-element array.
- Buffers one N x N operand matrix, row by row.
- On start, drives the array's left-edge operand inputs with the standard diagonal skew: lane i is delayed i cycles, so operands meet the correct partial sums inside the array.
- Each lane's output connects directly to the operand input of the first PE in row i.

Parameters:
- N, 4, array dimension: number of lanes, rows and columns.
- DW, 4, operand width in bits; matches the PE operand input width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately when asserted.
- load_valid  input  1  load_row holds a valid matrix row.
- load_ready  output  1  feeder accepts a row this cycle.
- load_row  input  N*DW  one row; column j at bits [DW*j +: DW].
- start  input  1  request to stream the buffered matrix.
- clear  input  1  discard the buffered matrix.
- busy  output  1  high while streaming.
- done  output  1  one-cycle pulse after the last skewed beat.
- edge_data  output  N*DW  lane i (row i) at bits [DW*i +: DW]; registered.
- edge_valid  output  N  per-lane valid for edge_data; registered.

Behaviour:
- Reset (async, rst=1):
  - state=EMPTY, row count=0, t=0.
  - edge_data=0, edge_valid=0, busy=0, done=0.
  - load_ready=1 once rst deasserts.
  - Buffer contents are don't-care.
  - Reset mid-stream aborts immediately; no done pulse.
- States: EMPTY, READY, STREAM.
- EMPTY:
  - load_ready=1.
  - A row is accepted on an edge with load_valid=1; it is written to buffer[row count], and row count increments.
  - When row N-1 is accepted, row count wraps to 0 and the state goes to READY on the same edge.
  - start and clear are ignored in EMPTY.
- READY:
  - load_ready=0; load_valid is ignored and no row is taken.
  - clear=1 -> EMPTY.
  - start=1 (with clear=0) -> STREAM, t=0. On that same edge, the t=0 outputs are registered.
  - If clear and start are both 1, clear wins.
- STREAM:
  - busy=1, load_ready=0.
  - Beat t spans 0..2N-2.
  - Lane i: edge_valid[i]=1 and edge_data lane i = buffer[i][t-i] when 0 <= t-i <= N-1; otherwise edge_valid[i]=0 and edge_data lane i = 0.
  - t increments each edge.
  - On the edge following beat t=2N-2: edge_data=0, edge_valid=0, busy=0, done=1 for exactly one cycle, and state -> EMPTY (base build).
  - start and clear are ignored during STREAM.
- Latency:
  - Lane 0 carries buffer[0][0] the cycle after start is sampled.
  - Lane i's first element appears i cycles later.
  - Total skewed window is 2N-1 cycles.
- Widths: t and row count are sized to hold 2N-2 and N-1 respectively. There is no arithmetic on data; values pass through unmodified.

Optional Feature:
- SKEW_FEEDER_REPEAT_EN.
- Defined:
  - At end of stream, state -> READY instead of EMPTY; the buffer is retained, so a subsequent start replays the same matrix.
  - done still pulses once per stream.
  - Only clear returns the feeder to EMPTY.
- Undefined: end of stream always -> EMPTY; the matrix must be reloaded before the next start.

Test Plan (N=4, DW=4, A[i][j]=4i+j):
- Load 4 rows back-to-back with load_valid held high -> 4 rows accepted on consecutive edges; load_ready=0 after the 4th edge; state READY.
- start for one cycle -> busy high for 7 cycles, then done for 1 cycle. Per-lane checks:
  - lane0 = 0,1,2,3 at t=0..3;
  - lane2 = 8,9,10,11 at t=2..5;
  - lane3 = 12..15 at t=3..6;
  - edge_valid pattern t0=0001, t3=1111, t6=1000.
- Assert start with 2 rows loaded, and load_valid during STREAM -> no stream starts, no rows accepted, row count unchanged.
- Assert rst at t=3 of a stream -> all outputs 0 the same cycle; no done pulse; load_ready=1 after release.
- In READY, drive start=1 and clear=1 together -> EMPTY, busy stays 0. After reloading, start -> normal stream.
- With SKEW_FEEDER_REPEAT_EN: stream, then start again without reloading -> identical 7-beat sequence; then clear -> load_ready=1.
